// File: rtl/hexstr_uart_tx_pkg.sv
// Shared constants and state types for the hex-string UART transmitter.
// The CR/LF terminator (HEXSTR_UART_CRLF_EN) is selected in hexstr_uart_tx.sv.
package hexstr_uart_tx_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // start + 8 data + stop
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StFinish
  } str_state_e;

  typedef enum logic {
    TxIdle,
    TxActive
  } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 frame generator. Holding valid high across a frame lets the next
// byte start in the cycle right after the stop bit, so frames run gapless.
module uart_tx_byte
  import hexstr_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam int unsigned     BaudW    = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BitLast  = 4'(UART_FRAME_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic [8:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             bit_end;
  logic             frame_end;

  assign bit_end   = (state_q == TxActive) && (baud_q == BaudLast);
  assign frame_end = bit_end && (bit_q == BitLast);
  assign ready     = (state_q == TxIdle) || frame_end;
  assign txd       = txd_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;

    if (bit_end) begin
      baud_d = '0;
      if (bit_q == BitLast) begin
        state_d = TxIdle;
        txd_d   = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        txd_d   = shift_q[0];
        shift_d = {1'b0, shift_q[8:1]};
      end
    end else if (state_q == TxActive) begin
      baud_d = baud_q + BaudW'(1);
    end

    // Acceptance overrides the stop-bit wrap, giving back-to-back frames.
    if (valid && ready) begin
      state_d = TxActive;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = {1'b1, data};
      txd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TxIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/hexstr_uart_tx.sv
// Latches an NCHARS-character ASCII string and sends it leftmost-first as 8N1 frames.
// Define HEXSTR_UART_CRLF_EN to append CR, LF frames after the string.
module hexstr_uart_tx
  import hexstr_uart_tx_pkg::*;
#(
  parameter int unsigned NCHARS       = 16,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [8*NCHARS-1:0] str_in,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                txd
);

`ifdef HEXSTR_UART_CRLF_EN
  localparam int unsigned NFRAMES = NCHARS + 2;
`else
  localparam int unsigned NFRAMES = NCHARS;
`endif
  localparam int unsigned      IdxW    = $clog2(NFRAMES + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NFRAMES - 1);

  str_state_e          state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [8*NCHARS-1:0] str_q, str_d;
  logic [IdxW-1:0]     sel;
  logic [7:0]          next_byte;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready;

  // Byte for the frame after the current one; it is offered while SEND runs.
  assign sel = idx_q + IdxW'(1);

  always_comb begin
    next_byte = ASCII_SPACE;
    for (int unsigned i = 0; i < NCHARS; i++) begin
      if (sel == IdxW'(i)) begin
        next_byte = str_q[8*(NCHARS-1-i) +: 8];
      end
    end
`ifdef HEXSTR_UART_CRLF_EN
    if (sel == IdxW'(NCHARS)) begin
      next_byte = ASCII_CR;
    end
    if (sel == IdxW'(NCHARS + 1)) begin
      next_byte = ASCII_LF;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    str_d    = str_q;
    tx_valid = 1'b0;
    tx_data  = next_byte;

    unique case (state_q)
      StIdle, StFinish: begin
        state_d = StIdle;
        if (start) begin
          // Character 0 goes straight from str_in so its start bit begins next cycle.
          str_d    = str_in;
          idx_d    = '0;
          tx_valid = 1'b1;
          tx_data  = str_in[8*NCHARS-1 -: 8];
          state_d  = StLoad;
        end
      end
      StLoad: begin
        state_d = StSend;
      end
      StSend: begin
        tx_valid = (idx_q != IdxLast);
        if (tx_ready) begin
          if (idx_q == IdxLast) begin
            state_d = StFinish;
          end else begin
            idx_d   = sel;
            state_d = StLoad;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      str_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      str_q   <= str_d;
    end
  end

  assign busy = (state_q == StLoad) || (state_q == StSend);
  assign done = (state_q == StFinish);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk  (clk),
    .rst_n(rst_n),
    .data (tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .txd  (txd)
  );

endmodule

// File: tb/tb_hexstr_uart_tx.sv
// Randomized bench for hexstr_uart_tx; expected line waveforms are built from the
// string contents and the 8N1 frame rule.
module tb_hexstr_uart_tx;

  localparam int unsigned NCH = 16;
  localparam int unsigned CPB = 4;
`ifdef HEXSTR_UART_CRLF_EN
  localparam int NFR = NCH + 2;
`else
  localparam int NFR = NCH;
`endif
  localparam int FRAME_CYC = 10 * CPB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [8*NCH-1:0] str_in = '0;
  logic             busy;
  logic             done;
  logic             txd;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hexstr_uart_tx #(
    .NCHARS      (NCH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .str_in(str_in),
    .start (start),
    .busy  (busy),
    .done  (done),
    .txd   (txd)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Frame f of a transmission: string characters left to right, then CR, LF.
  function automatic logic [7:0] exp_byte(input logic [8*NCH-1:0] s, input int f);
    if (f < NCH) return s[8*(NCH-1-f) +: 8];
    else if (f == NCH) return 8'h0D;
    else return 8'h0A;
  endfunction

  // Cycle-by-cycle line level for one frame: bit n occupies cycles n*CPB..n*CPB+CPB-1.
  function automatic logic [63:0] exp_frame(input logic [7:0] b);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < FRAME_CYC; j++) begin
      int bn;
      bn = j / CPB;
      if (bn == 0) v[j] = 1'b0;
      else if (bn == 9) v[j] = 1'b1;
      else v[j] = b[bn-1];
    end
    return v;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [8*NCH-1:0] make_hex_str(input logic [23:0] w);
    logic [8*NCH-1:0] s;
    for (int i = 0; i < NCH; i++) s[8*i +: 8] = 8'h20;
    for (int i = 0; i < 6; i++) s[8*(5-i) +: 8] = hex_ascii(w[23-4*i -: 4]);
    return s;
  endfunction

  function automatic logic [8*NCH-1:0] make_rand_str();
    logic [8*NCH-1:0] s;
    for (int i = 0; i < NCH; i++) s[8*i +: 8] = 8'($urandom_range(126, 32));
    return s;
  endfunction

  // Sends s (start already driven when prestarted=1). Optional extra start pulses at
  // noise1/noise2, a one-cycle reset at abort_at, and chaining into next_s on done.
  task automatic run_string(input logic [8*NCH-1:0] s, input bit prestarted, input int noise1,
                            input int noise2, input int abort_at, input bit chain,
                            input logic [8*NCH-1:0] next_s);
    logic [63:0] obs;
    int          bad;
    int          k;
    int          dones;
    if (!prestarted) begin
      str_in = s;
      start  = 1'b1;
    end
    for (int f = 0; f < NFR; f++) begin
      obs = '0;
      bad = 0;
      for (int j = 0; j < FRAME_CYC; j++) begin
        tick();
        k = f * FRAME_CYC + j;
        obs[j] = txd;
        if (busy !== 1'b1 || done !== 1'b0) bad++;
        start = 1'b0;
        if (k == noise1 || k == noise2) begin
          start  = 1'b1;
          str_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        if (k == abort_at) begin
          rst_n = 1'b0;
          tick();
          check_eq("abort_txd", {63'b0, txd}, 64'd1);
          check_eq("abort_busy", {63'b0, busy}, 64'd0);
          check_eq("abort_done", {63'b0, done}, 64'd0);
          rst_n = 1'b1;
          dones = 0;
          for (int c = 0; c < 3 * FRAME_CYC; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) dones++;
          end
          check_eq("abort_quiet", 64'(dones), 64'd0);
          return;
        end
      end
      check_eq($sformatf("frame%0d_byte%02h", f, exp_byte(s, f)), obs,
               exp_frame(exp_byte(s, f)));
      check_eq($sformatf("frame%0d_busy", f), 64'(bad), 64'd0);
    end
    tick();
    check_eq("done_pulse", {63'b0, done}, 64'd1);
    check_eq("done_busy_low", {63'b0, busy}, 64'd0);
    check_eq("done_txd_idle", {63'b0, txd}, 64'd1);
    if (chain) begin
      str_in = next_s;
      start  = 1'b1;
    end else begin
      tick();
      check_eq("done_one_cycle", {63'b0, done}, 64'd0);
      check_eq("after_txd_idle", {63'b0, txd}, 64'd1);
    end
  endtask

  initial begin
    logic [8*NCH-1:0] s_a;
    logic [8*NCH-1:0] s_b;
    int               bad_txd;
    int               bad_busy;
    int               bad_done;

    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_txd", {63'b0, txd}, 64'd1);
    check_eq("rst_busy", {63'b0, busy}, 64'd0);
    check_eq("rst_done", {63'b0, done}, 64'd0);
    rst_n = 1'b1;

    bad_txd = 0;
    bad_busy = 0;
    bad_done = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (txd !== 1'b1) bad_txd++;
      if (busy !== 1'b0) bad_busy++;
      if (done !== 1'b0) bad_done++;
    end
    check_eq("idle_txd", 64'(bad_txd), 64'd0);
    check_eq("idle_busy", 64'(bad_busy), 64'd0);
    check_eq("idle_done", 64'(bad_done), 64'd0);

    // Known hex string, then random hex and random printable strings.
    run_string(make_hex_str(24'h0A1B2C), 1'b0, -1, -1, -1, 1'b0, '0);
    repeat (2) run_string(make_hex_str(24'($urandom())), 1'b0, -1, -1, -1, 1'b0, '0);
    run_string(make_rand_str(), 1'b0, -1, -1, -1, 1'b0, '0);

    // Extra start pulses with a changing str_in while busy are ignored.
    run_string(make_hex_str(24'($urandom())), 1'b0, 50, 300, -1, 1'b0, '0);

    // Reset during character 5, then a full string from character 0.
    s_a = make_rand_str();
    run_string(s_a, 1'b0, -1, -1, 5 * FRAME_CYC + 13, 1'b0, '0);
    run_string(s_a, 1'b0, -1, -1, -1, 1'b0, '0);

    // Start in the done cycle: second string follows after one idle cycle.
    s_a = make_hex_str(24'($urandom()));
    s_b = make_rand_str();
    run_string(s_a, 1'b0, -1, -1, -1, 1'b1, s_b);
    run_string(s_b, 1'b1, -1, -1, -1, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
